control_sequencer: RTL and testbench

//  Hardwired control unit replacing hand-stepped T0..T7 bench stimulus. Fetches, decodes IR opcode and drives

---
 rtl/control_sequencer_if.sv | 43 ++++
 rtl/control_sequencer.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the datapath.
// The sequencer uses the master side. The datapath (or a bench) uses the slave side.
interface control_sequencer_if #(
    parameter int DATA_W    = 32,
    parameter int ALU_SEL_W = 4,
    parameter int CNT_W     = 16
);
    // Datapath status and operator controls seen by the sequencer
    logic [DATA_W-1:0]    ir;
    logic                 con_ff;
    logic                 mem_ready;
    logic                 run;
    logic                 stop;

    // Datapath strobes
    logic                 PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
    logic                 Yin, Zin, ZLowout, ZHighout;

    // Register-select and memory strobes
    logic                 Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, Read, Write;

    // ALU function and status
    logic [ALU_SEL_W-1:0] alu_sel;
    logic [3:0]           step;
    logic                 halted;
    logic                 fault;
    logic [1:0]           fault_code;
    logic [CNT_W-1:0]     instr_count;

    modport master (
        input  ir, con_ff, mem_ready, run, stop,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, ZLowout, ZHighout,
        output Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, Read, Write,
        output alu_sel, step, halted, fault, fault_code, instr_count
    );

    modport slave (
        output ir, con_ff, mem_ready, run, stop,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, ZLowout, ZHighout,
        input  Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, Read, Write,
        input  alu_sel, step, halted, fault, fault_code, instr_count
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit. It fetches an instruction, decodes the IR opcode and
// steps the datapath strobes through T0..T7. It also provides:
//  - memory wait states with a timeout,
//  - halt and run control,
//  - sticky fault reporting,
//  - a retired-instruction counter.
module control_sequencer #(
    parameter int DATA_W      = 32,
    parameter int OPC_W       = 5,
    parameter int ALU_SEL_W   = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    control_sequencer_if.master bus
);
    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    localparam logic [ALU_SEL_W-1:0] ALU_NONE  = ALU_SEL_W'(4'b0000);
    localparam logic [ALU_SEL_W-1:0] ALU_ADD   = ALU_SEL_W'(4'b0001);
    localparam logic [ALU_SEL_W-1:0] ALU_AND   = ALU_SEL_W'(4'b0110);
    localparam logic [ALU_SEL_W-1:0] ALU_OR    = ALU_SEL_W'(4'b0111);
    localparam logic [ALU_SEL_W-1:0] ALU_INCPC = ALU_SEL_W'(4'b1001);

    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(12);
    localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(13);
    localparam logic [OPC_W-1:0] OP_BR   = OPC_W'(18);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(27);

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    // Each instruction step gets its own state. The strobe decode is then a
    // function of the state register alone. S_IDLE is the reset state: it
    // shows step 0 with every strobe low. The FSM enters T0 on the first edge
    // after reset is released.
    typedef enum logic [4:0] {
        S_IDLE,
        S_T0, S_T1, S_T2,
        S_LD3, S_LD4, S_LD5, S_LD6, S_LD7,
        S_LDI3, S_LDI4, S_LDI5,
        S_ST3, S_ST4, S_ST5, S_ST6, S_ST7,
        S_AI3_ADD, S_AI3_AND, S_AI3_OR,
        S_AI4_ADD, S_AI4_AND, S_AI4_OR,
        S_AI5,
        S_BR3, S_BR4, S_BR5, S_BR6,
        S_HLT3,
        S_HALT,
        S_FAULT
    } state_t;

    state_t           state_reg, state_next;
    logic [TO_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [1:0]       fault_code_reg, fault_code_next;
    logic [CNT_W-1:0] instr_count_reg, instr_count_next;

    logic             retire;
    logic             in_wait;
    logic             timed_out;
    logic [OPC_W-1:0] opcode;
    logic             unused_ir_low;

    assign opcode        = bus.ir[DATA_W-1 -: OPC_W];
    assign unused_ir_low = ^bus.ir[DATA_W-OPC_W-1:0];
    assign timed_out     = (wait_cnt_reg == TO_LIMIT);

    // State, wait counter, fault code and retire counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= S_IDLE;
            wait_cnt_reg    <= '0;
            fault_code_reg  <= FC_NONE;
            instr_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            fault_code_reg  <= fault_code_next;
            instr_count_reg <= instr_count_next;
        end
    end

    // Next state: sequencing, opcode decode, wait/timeout, halt and fault control
    always_comb begin
        state_next      = state_reg;
        fault_code_next = fault_code_reg;
        retire          = 1'b0;
        in_wait         = 1'b0;
        unique case (state_reg)
            S_IDLE: state_next = S_T0;
            S_T0:   state_next = S_T1;
            S_T1: begin
                in_wait = 1'b1;
                if (bus.mem_ready) begin
                    state_next = S_T2;
                end else if (timed_out) begin
                    state_next      = S_FAULT;
                    fault_code_next = FC_TIMEOUT;
                end
            end
            S_T2: begin
                unique case (opcode)
                    OP_LD:   state_next = S_LD3;
                    OP_LDI:  state_next = S_LDI3;
                    OP_ST:   state_next = S_ST3;
                    OP_ADDI: state_next = S_AI3_ADD;
                    OP_ANDI: state_next = S_AI3_AND;
                    OP_ORI:  state_next = S_AI3_OR;
                    OP_BR:   state_next = S_BR3;
                    OP_HALT: state_next = S_HLT3;
                    default: begin
                        state_next      = S_FAULT;
                        fault_code_next = FC_ILLEGAL;
                    end
                endcase
            end
            S_LD3:  state_next = S_LD4;
            S_LD4:  state_next = S_LD5;
            S_LD5:  state_next = S_LD6;
            S_LD6: begin
                in_wait = 1'b1;
                if (bus.mem_ready) begin
                    state_next = S_LD7;
                end else if (timed_out) begin
                    state_next      = S_FAULT;
                    fault_code_next = FC_TIMEOUT;
                end
            end
            S_LDI3: state_next = S_LDI4;
            S_LDI4: state_next = S_LDI5;
            S_ST3:  state_next = S_ST4;
            S_ST4:  state_next = S_ST5;
            S_ST5:  state_next = S_ST6;
            S_ST6:  state_next = S_ST7;
            S_ST7: begin
                // The write wait state is also the last step of st.
                in_wait = 1'b1;
                if (bus.mem_ready) begin
                    retire     = 1'b1;
                    state_next = bus.stop ? S_HALT : S_T0;
                end else if (timed_out) begin
                    state_next      = S_FAULT;
                    fault_code_next = FC_TIMEOUT;
                end
            end
            S_AI3_ADD: state_next = S_AI4_ADD;
            S_AI3_AND: state_next = S_AI4_AND;
            S_AI3_OR:  state_next = S_AI4_OR;
            S_AI4_ADD, S_AI4_AND, S_AI4_OR: state_next = S_AI5;
            S_BR3:  state_next = S_BR4;
            S_BR4:  state_next = S_BR5;
            S_BR5:  state_next = S_BR6;
            S_LD7, S_LDI5, S_AI5, S_BR6: begin
                retire     = 1'b1;
                state_next = bus.stop ? S_HALT : S_T0;
            end
            S_HLT3: begin
                retire     = 1'b1;
                state_next = S_HALT;
            end
            S_HALT: begin
                if (bus.run && !bus.stop) state_next = S_T0;
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_IDLE;
        endcase

        // Wait counter counts held cycles and restarts on any state change.
        wait_cnt_next    = (in_wait && (state_next == state_reg)) ? wait_cnt_reg + TO_W'(1) : '0;
        instr_count_next = retire ? instr_count_reg + CNT_W'(1) : instr_count_reg;
    end

    // Strobe and step decode from the current state; everything low by default
    always_comb begin
        bus.PCout    = 1'b0;
        bus.PCin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.ZLowout  = 1'b0;
        bus.ZHighout = 1'b0;
        bus.Gra      = 1'b0;
        bus.Grb      = 1'b0;
        bus.Grc      = 1'b0;
        bus.Rin      = 1'b0;
        bus.Rout     = 1'b0;
        bus.BAout    = 1'b0;
        bus.Cout     = 1'b0;
        bus.CONin    = 1'b0;
        bus.Read     = 1'b0;
        bus.Write    = 1'b0;
        bus.alu_sel  = ALU_NONE;
        bus.step     = 4'd0;
        unique case (state_reg)
            S_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
                bus.alu_sel = ALU_INCPC;
            end
            S_T1: begin
                bus.step = 4'd1;
                bus.ZLowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
            end
            S_T2: begin
                bus.step = 4'd2;
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
            end
            S_LD3, S_LDI3, S_ST3: begin
                bus.step = 4'd3;
                bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
            end
            S_LD4, S_LDI4, S_ST4: begin
                bus.step = 4'd4;
                bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_sel = ALU_ADD;
            end
            S_LD5, S_ST5: begin
                bus.step = 4'd5;
                bus.ZLowout = 1'b1; bus.MARin = 1'b1;
            end
            S_LD6: begin
                bus.step = 4'd6;
                bus.Read = 1'b1; bus.MDRin = 1'b1;
            end
            S_LD7: begin
                bus.step = 4'd7;
                bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end
            S_LDI5, S_AI5: begin
                bus.step = 4'd5;
                bus.ZLowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end
            S_ST6: begin
                bus.step = 4'd6;
                bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
            end
            S_ST7: begin
                bus.step = 4'd7;
                bus.MDRout = 1'b1; bus.Write = 1'b1;
            end
            S_AI3_ADD, S_AI3_AND, S_AI3_OR: begin
                bus.step = 4'd3;
                bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
            end
            S_AI4_ADD: begin
                bus.step = 4'd4;
                bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_sel = ALU_ADD;
            end
            S_AI4_AND: begin
                bus.step = 4'd4;
                bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_sel = ALU_AND;
            end
            S_AI4_OR: begin
                bus.step = 4'd4;
                bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_sel = ALU_OR;
            end
            S_BR3: begin
                bus.step = 4'd3;
                bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1;
            end
            S_BR4: begin
                bus.step = 4'd4;
                bus.PCout = 1'b1; bus.Yin = 1'b1;
            end
            S_BR5: begin
                bus.step = 4'd5;
                bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_sel = ALU_ADD;
            end
            S_BR6: begin
                // con_ff is a datapath flop loaded in T3, so it is stable here.
                // Gating PCin with it adds no glitch.
                bus.step = 4'd6;
                bus.ZLowout = 1'b1; bus.PCin = bus.con_ff;
            end
            S_HLT3: bus.step = 4'd3;
            default: ;
        endcase
    end

    assign bus.halted      = (state_reg == S_HALT);
    assign bus.fault       = (state_reg == S_FAULT);
    assign bus.fault_code  = fault_code_reg;
    assign bus.instr_count = instr_count_reg;
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer. A table of expected strobes per
// (instruction, T-step) drives a cycle-by-cycle comparison. Memory latency,
// branch condition, stop requests and don't-care inputs are randomised.
module tb_control_sequencer;
    localparam int TO = 15;

    localparam int OP_LD = 0, OP_LDI = 1, OP_ST = 2, OP_ADDI = 11, OP_ANDI = 12;
    localparam int OP_ORI = 13, OP_BR = 18, OP_HALT = 27;

    localparam logic [20:0] M_PCOUT  = 21'(1) << 20;
    localparam logic [20:0] M_PCIN   = 21'(1) << 19;
    localparam logic [20:0] M_INCPC  = 21'(1) << 18;
    localparam logic [20:0] M_MARIN  = 21'(1) << 17;
    localparam logic [20:0] M_MDRIN  = 21'(1) << 16;
    localparam logic [20:0] M_MDROUT = 21'(1) << 15;
    localparam logic [20:0] M_IRIN   = 21'(1) << 14;
    localparam logic [20:0] M_YIN    = 21'(1) << 13;
    localparam logic [20:0] M_ZIN    = 21'(1) << 12;
    localparam logic [20:0] M_ZLOW   = 21'(1) << 11;
    localparam logic [20:0] M_GRA    = 21'(1) << 9;
    localparam logic [20:0] M_GRB    = 21'(1) << 8;
    localparam logic [20:0] M_RIN    = 21'(1) << 6;
    localparam logic [20:0] M_ROUT   = 21'(1) << 5;
    localparam logic [20:0] M_BAOUT  = 21'(1) << 4;
    localparam logic [20:0] M_COUT   = 21'(1) << 3;
    localparam logic [20:0] M_CONIN  = 21'(1) << 2;
    localparam logic [20:0] M_READ   = 21'(1) << 1;
    localparam logic [20:0] M_WRITE  = 21'(1);

    localparam logic [3:0] A_ADD = 4'b0001, A_AND = 4'b0110, A_OR = 4'b0111, A_INC = 4'b1001;

    // {step, halted, fault, alu_sel, strobes}
    localparam logic [30:0] V_ZERO  = 31'd0;
    localparam logic [30:0] V_HALT  = {4'd0, 1'b1, 1'b0, 25'd0};
    localparam logic [30:0] V_FAULT = {4'd0, 1'b0, 1'b1, 25'd0};

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   model_count = 0;

    control_sequencer_if #(.DATA_W(32), .ALU_SEL_W(4), .CNT_W(16)) bus ();

    control_sequencer #(
        .DATA_W(32), .OPC_W(5), .ALU_SEL_W(4), .MEM_TIMEOUT(TO), .CNT_W(16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [30:0] obs_vec();
        return {bus.step, bus.halted, bus.fault, bus.alu_sel,
                bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.IRin,
                bus.Yin, bus.Zin, bus.ZLowout, bus.ZHighout, bus.Gra, bus.Grb, bus.Grc,
                bus.Rin, bus.Rout, bus.BAout, bus.Cout, bus.CONin, bus.Read, bus.Write};
    endfunction

    function automatic bit legal(input int op);
        return op == OP_LD || op == OP_LDI || op == OP_ST || op == OP_ADDI ||
               op == OP_ANDI || op == OP_ORI || op == OP_BR || op == OP_HALT;
    endfunction

    // Index of the last T step of each instruction. An illegal opcode ends after T2.
    function automatic int last_step(input int op);
        case (op)
            OP_LD, OP_ST: return 7;
            OP_BR:        return 6;
            OP_HALT:      return 3;
            OP_LDI, OP_ADDI, OP_ANDI, OP_ORI: return 5;
            default:      return 2;
        endcase
    endfunction

    function automatic bit is_wait(input int op, input int t);
        return t == 1 || (op == OP_LD && t == 6) || (op == OP_ST && t == 7);
    endfunction

    // Microcode table: {alu_sel, strobes} expected for instruction op at step t
    function automatic logic [24:0] model_out(input int op, input int t, input bit cond);
        logic [20:0] s;
        logic [3:0]  a;
        s = '0;
        a = '0;
        if (t == 0) begin
            s = M_PCOUT | M_MARIN | M_INCPC | M_ZIN; a = A_INC;
        end else if (t == 1) begin
            s = M_ZLOW | M_PCIN | M_READ | M_MDRIN;
        end else if (t == 2) begin
            s = M_MDROUT | M_IRIN;
        end else if (op == OP_LD || op == OP_LDI || op == OP_ST) begin
            case (t)
                3: s = M_GRB | M_BAOUT | M_YIN;
                4: begin s = M_COUT | M_ZIN; a = A_ADD; end
                5: s = (op == OP_LDI) ? (M_ZLOW | M_GRA | M_RIN) : (M_ZLOW | M_MARIN);
                6: s = (op == OP_LD) ? (M_READ | M_MDRIN) : (M_GRA | M_ROUT | M_MDRIN);
                default: s = (op == OP_LD) ? (M_MDROUT | M_GRA | M_RIN) : (M_MDROUT | M_WRITE);
            endcase
        end else if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI) begin
            case (t)
                3: s = M_GRB | M_ROUT | M_YIN;
                4: begin
                    s = M_COUT | M_ZIN;
                    a = (op == OP_ADDI) ? A_ADD : (op == OP_ANDI) ? A_AND : A_OR;
                end
                default: s = M_ZLOW | M_GRA | M_RIN;
            endcase
        end else if (op == OP_BR) begin
            case (t)
                3: s = M_GRA | M_ROUT | M_CONIN;
                4: s = M_PCOUT | M_YIN;
                5: begin s = M_COUT | M_ZIN; a = A_ADD; end
                default: s = M_ZLOW | (cond ? M_PCIN : 21'd0);
            endcase
        end
        return {a, s};
    endfunction

    task automatic do_reset();
        bus.mem_ready = 1'b0; bus.run = 1'b0; bus.stop = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        model_count = 0;
    endtask

    // Steps one instruction from T0. d1 and d2 are the memory-ready delays of
    // the fetch and data wait states. A delay beyond TO must end in a timeout fault.
    task automatic run_instr(input logic [31:0] ir_val, input bit cond, input int d1,
                             input int d2, input bit stop_last, input string tag);
        int op, last, d, ncyc;
        bit w, faulted;
        logic [30:0] exp_v;
        op = int'(ir_val[31:27]);
        bus.ir = ir_val;
        bus.con_ff = cond;
        last = last_step(op);
        faulted = 1'b0;
        for (int t = 0; t <= last && !faulted; t++) begin
            w = is_wait(op, t);
            d = (t == 1) ? d1 : d2;
            ncyc = w ? ((d < TO) ? d : TO) : 0;
            for (int c = 0; c <= ncyc; c++) begin
                exp_v = {4'(t), 1'b0, 1'b0, model_out(op, t, cond)};
                checks++;
                if (obs_vec() !== exp_v) begin
                    errors++;
                    $display("FAIL %s T%0d cyc%0d outputs: got %h expected %h", tag, t, c, obs_vec(), exp_v);
                end
                bus.mem_ready = w ? (c >= d) : 1'($urandom_range(0, 1));
                bus.stop = (t == last) ? stop_last : 1'($urandom_range(0, 1));
                bus.run = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            if (w && d > TO) faulted = 1'b1;
        end
        if (faulted || !legal(op)) begin
            checks++;
            if (obs_vec() !== V_FAULT || bus.fault_code !== (faulted ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL %s fault entry: got %h code %b expected %h code %b", tag, obs_vec(),
                         bus.fault_code, V_FAULT, faulted ? 2'b10 : 2'b01);
            end
            for (int k = 0; k < 3; k++) begin
                bus.run = 1'b1; bus.stop = 1'(k & 1); bus.mem_ready = 1'b1;
                @(posedge clk); #1;
                checks++;
                if (obs_vec() !== V_FAULT || bus.instr_count !== 16'(model_count)) begin
                    errors++;
                    $display("FAIL %s fault sticky: got %h count %0d expected %h count %0d", tag,
                             obs_vec(), bus.instr_count, V_FAULT, model_count);
                end
            end
        end else begin
            model_count++;
            checks++;
            if (bus.instr_count !== 16'(model_count)) begin
                errors++;
                $display("FAIL %s instr_count: got %0d expected %0d", tag, bus.instr_count, model_count);
            end
            exp_v = (op == OP_HALT || stop_last) ? V_HALT : {7'd0, model_out(0, 0, 1'b0)};
            checks++;
            if (obs_vec() !== exp_v) begin
                errors++;
                $display("FAIL %s after retire: got %h expected %h", tag, obs_vec(), exp_v);
            end
        end
        bus.run = 1'b0; bus.stop = 1'b0; bus.mem_ready = 1'b0;
        $display("instr %s ir=%h con=%0d d1=%0d d2=%0d stop=%0d count=%0d", tag, ir_val, cond, d1, d2,
                 stop_last, bus.instr_count);
    endtask

    // From HALT: run with stop holds, run alone restarts at T0
    task automatic resume_from_halt(input string tag);
        bus.run = 1'b1; bus.stop = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs_vec() !== V_HALT) begin
            errors++;
            $display("FAIL %s run+stop: got %h expected %h", tag, obs_vec(), V_HALT);
        end
        bus.stop = 1'b0;
        @(posedge clk); #1;
        bus.run = 1'b0;
        checks++;
        if (obs_vec() !== {7'd0, model_out(0, 0, 1'b0)}) begin
            errors++;
            $display("FAIL %s resume T0: got %h expected %h", tag, obs_vec(), {7'd0, model_out(0, 0, 1'b0)});
        end
    endtask

    task automatic test_reset();
        bus.ir = '0; bus.con_ff = 1'b0;
        bus.mem_ready = 1'b0; bus.run = 1'b0; bus.stop = 1'b0;
        reset_n = 1'b0;
        #3;
        checks++;
        if (obs_vec() !== V_ZERO || bus.instr_count !== 16'd0 || bus.fault_code !== 2'b00) begin
            errors++;
            $display("FAIL reset state: got %h count %0d code %b expected all zero", obs_vec(),
                     bus.instr_count, bus.fault_code);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        checks++;
        if (obs_vec() !== V_ZERO) begin
            errors++;
            $display("FAIL reset release idle: got %h expected %h", obs_vec(), V_ZERO);
        end
        @(posedge clk); #1;
        checks++;
        if (obs_vec() !== {7'd0, model_out(0, 0, 1'b0)}) begin
            errors++;
            $display("FAIL reset first edge T0: got %h expected %h", obs_vec(), {7'd0, model_out(0, 0, 1'b0)});
        end
        model_count = 0;
        $display("reset done");
    endtask

    task automatic test_ld();
        run_instr(32'h00800055, 1'b0, 1, 1, 1'b0, "ld_late");
        run_instr(32'h00800055, 1'b1, 0, 0, 1'b0, "ld_fast");
    endtask

    task automatic test_alu();
        run_instr(32'h590FFFFB, 1'b0, 0, 0, 1'b0, "addi");
        run_instr(32'h6108001A, 1'b0, 0, 0, 1'b0, "andi");
        run_instr(32'h6908001A, 1'b1, 2, 0, 1'b0, "ori");
    endtask

    task automatic test_branch();
        run_instr(32'h91000023, 1'b1, 0, 0, 1'b0, "br_taken");
        run_instr(32'h91000023, 1'b0, 0, 0, 1'b0, "br_not_taken");
    endtask

    task automatic test_stop_run();
        run_instr(32'h10800055, 1'b0, 0, 2, 1'b1, "st_stop");
        for (int k = 0; k < 3; k++) begin
            bus.run = 1'b1; bus.stop = 1'b1; bus.mem_ready = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (obs_vec() !== V_HALT || bus.instr_count !== 16'(model_count)) begin
                errors++;
                $display("FAIL halt hold %0d: got %h count %0d expected %h count %0d", k, obs_vec(),
                         bus.instr_count, V_HALT, model_count);
            end
        end
        resume_from_halt("st_resume");
        run_instr(32'hD8000000, 1'b0, 0, 0, 1'b0, "halt");
        resume_from_halt("halt_resume");
    endtask

    task automatic test_timeout();
        run_instr(32'h00800055, 1'b0, TO, TO, 1'b0, "ld_edge_of_timeout");
        run_instr(32'h10800055, 1'b0, 0, TO, 1'b0, "st_edge_of_timeout");
        run_instr(32'h00800055, 1'b0, TO + 1, 0, 1'b0, "fetch_timeout");
        do_reset();
        run_instr(32'h10800055, 1'b0, 0, TO + 1, 1'b0, "st_timeout");
        do_reset();
    endtask

    task automatic test_illegal();
        run_instr(32'h590FFFFB, 1'b0, 0, 0, 1'b0, "pre_illegal");
        run_instr(32'hF8000000, 1'b0, 0, 0, 1'b0, "illegal31");
        do_reset();
        run_instr(32'h18000000, 1'b0, 0, 0, 1'b0, "illegal3");
        do_reset();
    endtask

    task automatic test_reset_mid();
        run_instr(32'h590FFFFB, 1'b0, 0, 0, 1'b0, "pre_ldi");
        bus.ir = 32'h08800055;
        bus.mem_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.step !== 4'd5) begin
            errors++;
            $display("FAIL reset_mid reach T5: got step %0d expected 5", bus.step);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== V_ZERO || bus.instr_count !== 16'd0 || bus.fault_code !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid outputs: got %h count %0d expected zero", obs_vec(), bus.instr_count);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        model_count = 0;
        checks++;
        if (obs_vec() !== {7'd0, model_out(0, 0, 1'b0)} || bus.instr_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid restart T0: got %h count %0d expected %h count 0", obs_vec(),
                     bus.instr_count, {7'd0, model_out(0, 0, 1'b0)});
        end
        $display("reset mid-ldi done");
    endtask

    task automatic test_random();
        int ops[8] = '{OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ANDI, OP_ORI, OP_BR, OP_HALT};
        int op, d1, d2;
        bit st;
        logic [31:0] r;
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 7)];
            r = $urandom();
            d1 = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3);
            d2 = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3);
            st = ($urandom_range(0, 7) == 0);
            run_instr({5'(op), r[26:0]}, 1'($urandom_range(0, 1)), d1, d2, st, "random");
            if (st || op == OP_HALT) resume_from_halt("random_resume");
        end
    endtask

    initial begin
        test_reset();
        test_ld();
        test_alu();
        test_branch();
        test_stop_run();
        test_timeout();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
